// File: rtl/gtech_oai22_arb.sv
// Round-robin arbiter sharing one OAI22 evaluation among N_REQ requesters.
// Results go through a single-entry slot that can drain and refill on the same edge.
module gtech_oai22_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                 cp_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [4*N_REQ-1:0]   req_ops_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_z_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic                 busy_o,
    output logic [CNTW-1:0]      done_cnt_o
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_z_q, rsp_z_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;

    logic            slotOpen;
    logic            drain;
    logic            grantFound;
    logic            grant;
    logic [IDW-1:0]  grantIdx;
    logic [3:0]      selOps;
    logic [N_REQ-1:0] reqReady;
    int              searchIdx;

    assign slotOpen = !rsp_valid_q || rsp_ready_i;
    assign drain    = rsp_valid_q && rsp_ready_i;

    // Scan from the pointer, wrapping, and take the first valid requester.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        searchIdx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            searchIdx = (int'(ptr_q) + k) % N_REQ;
            if (!grantFound && req_valid_i[searchIdx]) begin
                grantFound = 1'b1;
                grantIdx   = IDW'(searchIdx);
            end
        end
    end

    always_comb begin
        reqReady = '0;
        grant    = 1'b0;
        if (grantFound && en_i && slotOpen && !rst_i) begin
            reqReady[grantIdx] = 1'b1;
            grant              = 1'b1;
        end
    end

    assign selOps = req_ops_i[4*int'(grantIdx) +: 4];

    // A grant overwrites the slot even when it is draining on the same edge.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        done_cnt_d  = done_cnt_q;
        if (drain) begin
            rsp_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + 1'b1;
        end
        if (grant) begin
            rsp_valid_d = 1'b1;
            rsp_z_d     = ~((selOps[0] | selOps[1]) & (selOps[2] | selOps[3]));
            rsp_id_d    = grantIdx;
            ptr_d       = (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + 1'b1;
        end
    end

    always_ff @(posedge cp_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_id_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign req_ready_o = reqReady;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_z_o     = rsp_z_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = rsp_valid_q || (|req_valid_i);
    assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_gtech_oai22_arb.sv
// Directed and random stimulus for gtech_oai22_arb against a queue-free behavioural model.
// The counter is built 4 bits wide so its wrap is reachable in a short run.
module tb_gtech_oai22_arb;

    localparam int N = 4;

    logic        cp;
    logic        rst;
    logic        en;
    logic [3:0]  reqValid;
    logic [15:0] reqOps;
    logic [3:0]  reqReady;
    logic        rspValid;
    logic        rspReady;
    logic        rspZ;
    logic [1:0]  rspId;
    logic        busy;
    logic [3:0]  doneCnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the slot, pointer and completion count
    int mPtr   = 0;
    bit mValid = 0;
    bit mZ     = 0;
    int mId    = 0;
    int mCnt   = 0;

    gtech_oai22_arb #(.N_REQ(4), .IDW(2), .CNTW(4)) dut (
        .cp_i        (cp),
        .rst_i       (rst),
        .en_i        (en),
        .req_valid_i (reqValid),
        .req_ops_i   (reqOps),
        .req_ready_o (reqReady),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_z_o     (rspZ),
        .rsp_id_o    (rspId),
        .busy_o      (busy),
        .done_cnt_o  (doneCnt)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check pre-edge outputs against the model, then advance the model.
    task automatic applyStimulus(input bit r, input bit e, input logic [3:0] v,
                                 input logic [15:0] ops, input bit rdy, input string tag);
        int g;
        int idx;
        bit a, b, c, d;
        bit drainNow;
        logic [3:0] expReady;
        rst = r; en = e; reqValid = v; reqOps = ops; rspReady = rdy;
        #2;
        g = -1;
        if (!r && e && (!mValid || rdy)) begin
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        expReady = (g >= 0) ? 4'(1 << g) : 4'd0;
        checkOutput({tag, ".ready"}, 32'(reqReady), 32'(expReady));
        checkOutput({tag, ".valid"}, 32'(rspValid), 32'(mValid));
        checkOutput({tag, ".z"},     32'(rspZ),     32'(mZ));
        checkOutput({tag, ".id"},    32'(rspId),    32'(mId));
        checkOutput({tag, ".busy"},  32'(busy),     32'(mValid || (v != 4'd0)));
        checkOutput({tag, ".cnt"},   32'(doneCnt),  32'(mCnt));
        @(posedge cp);
        #1;
        if (r) begin
            mPtr = 0; mValid = 0; mZ = 0; mId = 0; mCnt = 0;
        end else begin
            drainNow = mValid && rdy;
            if (drainNow) begin
                mCnt   = (mCnt + 1) % 16;
                mValid = 0;
            end
            if (g >= 0) begin
                a = ops[4*g]; b = ops[4*g+1]; c = ops[4*g+2]; d = ops[4*g+3];
                mValid = 1;
                mZ     = !((a || b) && (c || d));
                mId    = g;
                mPtr   = (g + 1) % N;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; reqValid = 4'd0; reqOps = 16'd0; rspReady = 1'b0;
        @(posedge cp);
        #1;

        // Reset holds everything quiet even with requests pending
        applyStimulus(1, 1, 4'b1111, 16'hFFFF, 1, "rst");
        applyStimulus(1, 1, 4'b0101, 16'h1234, 0, "rst2");

        // Single request from requester 0, ops 0101 gives Z=0
        rst = 0; en = 1; reqValid = 4'b0001; reqOps = 16'h0005; rspReady = 1;
        #2;
        checkOutput("first.ready_const", 32'(reqReady), 32'h1);
        applyStimulus(0, 1, 4'b0001, 16'h0005, 1, "first");
        checkOutput("first.valid_const", 32'(rspValid), 32'h1);
        checkOutput("first.z_const", 32'(rspZ), 32'h0);
        checkOutput("first.id_const", 32'(rspId), 32'h0);
        applyStimulus(0, 1, 4'b0000, 16'h0000, 1, "first_drain");
        checkOutput("first.cnt_const", 32'(doneCnt), 32'h1);

        // All requesters valid: grant order 0,1,2,3,0,1,2,3
        applyStimulus(1, 1, 4'b0000, 16'h0000, 0, "rr_reset");
        for (int i = 0; i < 8; i++) begin
            rst = 0; en = 1; reqValid = 4'b1111; rspReady = 1;
            #1;
            checkOutput("rr.order", 32'(reqReady), 32'(1 << (i % 4)));
            applyStimulus(0, 1, 4'b1111, 16'($urandom), 1, "rr");
        end
        applyStimulus(0, 1, 4'b0000, 16'h0000, 1, "rr_drain");
        checkOutput("rr.cnt8", 32'(doneCnt), 32'h8);

        // Stall: slot full with consumer not ready, then drain-and-refill
        applyStimulus(0, 1, 4'b0001, 16'h000F, 0, "stall_fill");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 4'b0110, 16'($urandom), 0, "stall");
        applyStimulus(0, 1, 4'b0110, 16'h0A50, 1, "stall_release");

        // Grant enable low: slot drains, no grant, pointer kept
        applyStimulus(0, 0, 4'b1111, 16'($urandom), 1, "en_off");
        applyStimulus(0, 0, 4'b1111, 16'($urandom), 1, "en_off2");
        applyStimulus(0, 1, 4'b1111, 16'($urandom), 1, "en_on");

        // Reset with slot in flight, then lone requester 3 is granted
        applyStimulus(0, 1, 4'b0010, 16'h00F0, 0, "rst_fill");
        applyStimulus(1, 1, 4'b1000, 16'hF000, 0, "rst_flight");
        applyStimulus(0, 1, 4'b1000, 16'h3000, 1, "rst_after");
        checkOutput("rst_after.id3", 32'(rspId), 32'h3);

        // Sweep all operand values through requester 2, wrapping the counter
        applyStimulus(1, 1, 4'b0000, 16'h0000, 0, "sweep_reset");
        for (int val = 0; val < 16; val++) begin
            applyStimulus(0, 1, 4'b0100, 16'(val << 8), 1, "sweep");
            checkOutput("sweep.z_direct", 32'(rspZ),
                        32'(!(((val & 1) != 0 || (val & 2) != 0) && ((val & 4) != 0 || (val & 8) != 0))));
            checkOutput("sweep.id2", 32'(rspId), 32'h2);
        end
        applyStimulus(0, 1, 4'b0000, 16'h0000, 1, "sweep_drain");
        checkOutput("sweep.cnt_wrap", 32'(doneCnt), 32'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                          4'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gtech_oai22_arb.md
GTECH_OAI22_ARB -- requirements
Module: gtech_oai22_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IDW, default 2, width of requester ID, equal to clog2(N_REQ).
REQ-003 SHALL have parameter CNTW, default 16, width of the completion counter.
REQ-004 CP  in  1  clock; all state changes occur on the rising edge.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 EN  in  1  grant enable; while low, no new grants are issued.
REQ-007 REQ_VALID  in  N_REQ  per-requester request valid.
REQ-008 REQ_OPS  in  4*N_REQ  per-requester operands; bits [4i+3:4i] = {D,C,B,A} of requester i.
REQ-009 REQ_READY  out  N_REQ  one-hot (or zero) grant; request i is accepted when REQ_VALID[i] and REQ_READY[i] are both high at a rising edge.
REQ-010 RSP_VALID  out  1  result slot holds a valid result.
REQ-011 RSP_READY  in  1  consumer accepts the result.
REQ-012 RSP_Z  out  1  result ~((A|B)&(C|D)) of the accepted operands.
REQ-013 RSP_ID  out  IDW  index of the requester that owns RSP_Z.
REQ-014 BUSY  out  1  high when RSP_VALID is high or any REQ_VALID bit is high.
REQ-015 DONE_CNT  out  CNTW  count of completed response handshakes.

Function
REQ-016 The block SHALL share one OAI22 evaluation among N_REQ requesters through a single-entry result slot {Z, ID, valid}.
REQ-017 The slot SHALL be "open" in a cycle when RSP_VALID is low, or when RSP_VALID and RSP_READY are both high.
REQ-018 REQ_READY SHALL be non-zero only when EN is high, the slot is open, and at least one REQ_VALID bit is high; it SHALL be a combinational function of REQ_VALID, EN, slot state, RSP_READY and the RR pointer.
REQ-019 Arbitration SHALL be round-robin: the search starts at index PTR and wraps modulo N_REQ; the first valid index is granted.
REQ-020 On a grant to index g, PTR SHALL update to (g+1) mod N_REQ at the same edge; PTR SHALL be unchanged in cycles without a grant.
REQ-021 On a grant, the slot SHALL load Z = ~((A|B)&(C|D)) from REQ_OPS of index g, ID = g, and valid = 1 at that edge; latency from accepting edge to RSP_VALID high is 0 cycles (visible immediately after the edge).
REQ-022 Simultaneous drain and grant in the same cycle SHALL replace the slot contents, with RSP_VALID remaining high, giving a throughput of 1 result/cycle.
REQ-023 A drain without a grant SHALL clear RSP_VALID at that edge.
REQ-024 While RSP_VALID is high and RSP_READY is low, RSP_Z and RSP_ID SHALL hold stable and REQ_READY SHALL be all-zero.
REQ-025 DONE_CNT SHALL increment by 1 on each edge where RSP_VALID and RSP_READY are both high, wrapping from 2^CNTW-1 to 0.
REQ-026 EN low SHALL block grants only; an occupied slot SHALL still drain normally.
REQ-027 REQ_VALID deasserted before a grant SHALL be dropped silently; the block holds no per-requester state.

Reset
REQ-028 While RST is high at an edge: RSP_VALID=0, RSP_Z=0, RSP_ID=0, PTR=0, DONE_CNT=0.
REQ-029 During a cycle with RST high, REQ_READY SHALL be all-zero, and no grant or drain SHALL be recorded; a slot in flight is discarded.
REQ-030 In the first cycle after reset, requester 0 SHALL have the highest priority.

Verification
REQ-031 Reset, then REQ_VALID=4'b0001 with ops {D,C,B,A}=4'b0101, RSP_READY=1 -> REQ_READY=4'b0001; next cycle RSP_VALID=1, RSP_Z=0, RSP_ID=0; DONE_CNT=1 one edge later.
REQ-032 REQ_VALID=4'b1111 held, RSP_READY=1, EN=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one result per cycle; DONE_CNT=8 after the final drain.
REQ-033 Slot full with RSP_READY=0 for 3 cycles, REQ_VALID=4'b0110 -> REQ_READY=0 and RSP_Z/RSP_ID stable; on RSP_READY=1, the grant goes to PTR-ordered index with drain-and-refill in the same edge.
REQ-034 EN=0 with slot full and RSP_READY=1 -> slot drains (RSP_VALID falls), no grant; EN=1 -> grants resume from the unchanged PTR.
REQ-035 RST asserted while RSP_VALID=1 and REQ_VALID=4'b1000 -> after the edge, RSP_VALID=0, DONE_CNT=0, PTR=0; next grant goes to index 3 if it is the only valid requester.
REQ-036 Ops sweep: all 16 {D,C,B,A} values via requester 2 -> RSP_Z=0 exactly when (A|B)&(C|D), otherwise 1; RSP_ID=2 each time; DONE_CNT wrap is checked with CNTW=4 after 16 completions -> 0.
